// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for pipe_alu and its iterative multiply/divide unit.
package alu_pkg;

  typedef enum logic [3:0] {
    OpPass  = 4'h0,
    OpAdd   = 4'h1,
    OpSub   = 4'h2,
    OpMul   = 4'h3,
    OpUdiv  = 4'h4,
    OpUrem  = 4'h5,
    OpAnd   = 4'h6,
    OpOr    = 4'h7,
    OpXor   = 4'h8,
    OpLsh   = 4'h9,
    OpAsh   = 4'hA,
    OpSlt   = 4'hB,
    OpSltu  = 4'hC,
    OpRsvdD = 4'hD,
    OpRsvdE = 4'hE,
    OpRsvdF = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StIter,
    StDone
  } state_e;

  // Ops that run through the bit-serial multiply/divide unit.
  function automatic logic is_iter_op(alu_op_e op);
    return (op == OpMul) || (op == OpUdiv) || (op == OpUrem);
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Bit-serial unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// Ports: clk/rst; start loads op/a/b; done is high during the final step, with
// result/ofl/err valid in that same cycle (taken from the final step's next value).
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ofl,
  output logic             err
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic               r_busy;
  logic [CntW-1:0]    r_cnt;
  alu_op_e            r_op;
  logic [WIDTH-1:0]   r_opnd;  // multiplicand (mul) or divisor (div/rem)
  logic [2*WIDTH-1:0] r_acc;   // mul: {hi, lo/multiplier}; div: {remainder, quotient/dividend}

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_sh;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_acc_next;

  // Multiply step: add multiplicand into the high half if the current multiplier bit is set,
  // then shift the whole accumulator right, carry included.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

  // Restoring divide step: shift next dividend bit into the remainder, subtract if it fits.
  // With a zero divisor every trial fits, so the quotient fills with ones and the remainder
  // ends up equal to the dividend, which is exactly the required b == 0 result.
  assign w_sh       = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_sh - {1'b0, r_opnd};
  assign w_ge       = (w_sh >= {1'b0, r_opnd});
  assign w_rem      = w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
  assign w_div_next = {w_rem, r_acc[WIDTH-2:0], w_ge};

  assign w_acc_next = (r_op == OpMul) ? w_mul_next : w_div_next;

  assign done = r_busy && (r_cnt == CntLast);

  always_comb begin
    result = '0;
    ofl    = 1'b0;
    err    = 1'b0;
    unique case (r_op)
      OpMul: begin
        result = w_acc_next[WIDTH-1:0];
        ofl    = |w_acc_next[2*WIDTH-1:WIDTH];
      end
      OpUdiv: begin
        result = w_acc_next[WIDTH-1:0];
        err    = (r_opnd == '0);
      end
      OpUrem: begin
        result = w_acc_next[2*WIDTH-1:WIDTH];
        err    = (r_opnd == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_op   <= OpMul;
      r_opnd <= '0;
      r_acc  <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_op   <= op;
      r_opnd <= (op == OpMul) ? a : b;
      r_acc  <= (op == OpMul) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
    end else if (r_busy) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + 1'b1;
      if (done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end
    end
  end

endmodule

// File: rtl/pipe_alu.sv
// Handshaked ALU: single-cycle ops execute in one EXEC cycle, mul/udiv/urem iterate in
// iter_muldiv. Ports: in_valid/in_ready + alu_op/a/b request; out_valid/out_ready + c/ofl/err
// result, held stable for as long as out_valid is high.
module pipe_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             ofl,
  output logic             err
);

  localparam logic [WIDTH-1:0] WMax = WIDTH'(WIDTH);

  state_e           r_state, w_state_d;
  alu_op_e          r_op;
  logic [WIDTH-1:0] r_a, r_b, r_c;
  logic             r_ofl, r_err;

  alu_op_e          w_op;
  logic             w_accept;
  logic             w_it_start, w_it_done, w_it_ofl, w_it_err;
  logic [WIDTH-1:0] w_it_result;

  logic [WIDTH:0]   w_add, w_sub;
  logic [WIDTH-1:0] w_ramt, w_shl, w_lsr, w_asr;
  logic [WIDTH-1:0] w_exec_c;
  logic             w_exec_ofl, w_exec_err;

  assign w_op       = alu_op_e'(alu_op);
  assign in_ready   = (r_state == StIdle);
  assign w_accept   = in_valid && in_ready;
  assign w_it_start = w_accept && is_iter_op(w_op);

  iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (w_it_start),
    .op    (w_op),
    .a     (a),
    .b     (b),
    .done  (w_it_done),
    .result(w_it_result),
    .ofl   (w_it_ofl),
    .err   (w_it_err)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (w_accept) w_state_d = is_iter_op(w_op) ? StIter : StExec;
      StExec: w_state_d = StDone;
      StIter: if (w_it_done) w_state_d = StDone;
      StDone: if (out_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  assign w_add = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub = {1'b0, r_a} - {1'b0, r_b};  // top bit is the borrow

  // Shift count is b as a signed value; negating the most-negative b leaves it unchanged,
  // and as an unsigned right-shift amount it is >= WIDTH, so it saturates like any large count.
  assign w_ramt = -r_b;
  assign w_shl  = (r_b >= WMax) ? '0 : (r_a << r_b);
  assign w_lsr  = (w_ramt >= WMax) ? '0 : (r_a >> w_ramt);
  assign w_asr  = (w_ramt >= WMax) ? {WIDTH{r_a[WIDTH-1]}}
                                   : WIDTH'($signed(r_a) >>> w_ramt);

  always_comb begin
    w_exec_c   = '0;
    w_exec_ofl = 1'b0;
    w_exec_err = 1'b0;
    unique case (r_op)
      OpPass: w_exec_c = r_a;
      OpAdd: begin
        w_exec_c   = w_add[WIDTH-1:0];
        w_exec_ofl = w_add[WIDTH];
      end
      OpSub: begin
        w_exec_c   = w_sub[WIDTH-1:0];
        w_exec_ofl = w_sub[WIDTH];
      end
      OpAnd:  w_exec_c = r_a & r_b;
      OpOr:   w_exec_c = r_a | r_b;
      OpXor:  w_exec_c = r_a ^ r_b;
      OpLsh:  w_exec_c = r_b[WIDTH-1] ? w_lsr : w_shl;
      OpAsh:  w_exec_c = r_b[WIDTH-1] ? w_asr : w_shl;
      OpSlt:  w_exec_c = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      OpSltu: w_exec_c = {{(WIDTH-1){1'b0}}, (r_a < r_b)};
      OpMul, OpUdiv, OpUrem, OpRsvdD, OpRsvdE, OpRsvdF: w_exec_err = 1'b1;
      default: w_exec_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op  <= OpPass;
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= '0;
      r_ofl <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= w_op;
        r_a  <= a;
        r_b  <= b;
      end
      if (r_state == StExec) begin
        r_c   <= w_exec_c;
        r_ofl <= w_exec_ofl;
        r_err <= w_exec_err;
      end else if ((r_state == StIter) && w_it_done) begin
        r_c   <= w_it_result;
        r_ofl <= w_it_ofl;
        r_err <= w_it_err;
      end
    end
  end

  assign out_valid = (r_state == StDone);
  assign c         = r_c;
  assign ofl       = r_ofl;
  assign err       = r_err;

endmodule

// File: tb/tb_pipe_alu.sv
module tb_pipe_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] c;
  logic        ofl, err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic        ofl;
    logic        err;
    logic [7:0]  lat;
  } vec_t;

  pipe_alu #(
    .WIDTH(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .c        (c),
    .ofl      (ofl),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Drive one request (called #1 after an edge, in IDLE) and wait for the result.
  // lat counts rising edges from the drive point until out_valid is seen.
  task automatic run_op(input logic [3:0] op, input logic [15:0] va, input logic [15:0] vb,
                        output int lat, output logic [15:0] rc, output logic rofl,
                        output logic rerr);
    alu_op   = op;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    lat      = 0;
    do begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = 16'hDEAD;  // operands must not matter after accept
      b        = 16'hBEEF;
      lat++;
    end while (!out_valid && lat < 100);
    rc   = c;
    rofl = ofl;
    rerr = err;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_op    = 4'h0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || c !== 16'h0 || ofl !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got out_valid=%b c=%h ofl=%b err=%b exp 0 0000 0 0",
               out_valid, c, ofl, err);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
    end
  endtask

  task automatic check_table(input string name, input vec_t v [], input int n);
    int          lat;
    logic [15:0] rc;
    logic        rofl, rerr;
    for (int i = 0; i < n; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, lat, rc, rofl, rerr);
      n_checks++;
      if (rc !== v[i].c || rofl !== v[i].ofl || rerr !== v[i].err || lat != int'(v[i].lat)) begin
        n_fail++;
        $display("FAIL %s[%0d] op=%h a=%h b=%h got c=%h ofl=%b err=%b lat=%0d exp c=%h ofl=%b err=%b lat=%0d",
                 name, i, v[i].op, v[i].a, v[i].b, rc, rofl, rerr, lat,
                 v[i].c, v[i].ofl, v[i].err, v[i].lat);
      end
    end
  endtask

  task automatic test_single();
    vec_t v [];
    v = new[12];
    v[0]  = '{4'h1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 8'd2};
    v[1]  = '{4'h1, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b0, 8'd2};
    v[2]  = '{4'h2, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 8'd2};
    v[3]  = '{4'h2, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 8'd2};
    v[4]  = '{4'h0, 16'h00AB, 16'h5555, 16'h00AB, 1'b0, 1'b0, 8'd2};
    v[5]  = '{4'h6, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 8'd2};
    v[6]  = '{4'h7, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 1'b0, 8'd2};
    v[7]  = '{4'h8, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0, 1'b0, 8'd2};
    v[8]  = '{4'hB, 16'h8000, 16'h0001, 16'h0001, 1'b0, 1'b0, 8'd2};
    v[9]  = '{4'hC, 16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b0, 8'd2};
    v[10] = '{4'hD, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 8'd2};
    v[11] = '{4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 8'd2};
    check_table("single", v, 12);
  endtask

  task automatic test_muldiv();
    vec_t v [];
    v = new[7];
    v[0] = '{4'h3, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 8'd17};
    v[1] = '{4'h3, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0, 8'd17};
    v[2] = '{4'h3, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 8'd17};
    v[3] = '{4'h4, 16'h0064, 16'h0007, 16'h000E, 1'b0, 1'b0, 8'd17};
    v[4] = '{4'h5, 16'h0064, 16'h0007, 16'h0002, 1'b0, 1'b0, 8'd17};
    v[5] = '{4'h4, 16'h0064, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 8'd17};
    v[6] = '{4'h5, 16'h0064, 16'h0000, 16'h0064, 1'b0, 1'b1, 8'd17};
    check_table("muldiv", v, 7);
  endtask

  task automatic test_shift();
    vec_t v [];
    v = new[8];
    v[0] = '{4'hA, 16'h8000, 16'hFFFC, 16'hF800, 1'b0, 1'b0, 8'd2};
    v[1] = '{4'h9, 16'h8000, 16'hFFFC, 16'h0800, 1'b0, 1'b0, 8'd2};
    v[2] = '{4'h9, 16'h0001, 16'h0010, 16'h0000, 1'b0, 1'b0, 8'd2};
    v[3] = '{4'h9, 16'h0001, 16'h0004, 16'h0010, 1'b0, 1'b0, 8'd2};
    v[4] = '{4'hA, 16'h8000, 16'h8000, 16'hFFFF, 1'b0, 1'b0, 8'd2};
    v[5] = '{4'h9, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0, 8'd2};
    v[6] = '{4'hA, 16'h4000, 16'hFFF0, 16'h0000, 1'b0, 1'b0, 8'd2};
    v[7] = '{4'hA, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 8'd2};
    check_table("shift", v, 8);
  endtask

  task automatic test_stall();
    int lat;
    alu_op   = 4'h1;
    a        = 16'h0005;
    b        = 16'h0003;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_checks++;
    if (lat != 2) begin
      n_fail++;
      $display("FAIL stall_latency got %0d exp 2", lat);
    end
    // New request while DONE must be ignored.
    alu_op   = 4'h0;
    a        = 16'h7777;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || c !== 16'h0008 || ofl !== 1'b0 || err !== 1'b0 ||
          in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got out_valid=%b c=%h ofl=%b err=%b in_ready=%b exp 1 0008 0 0 0",
                 i, out_valid, c, ofl, err, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release got out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_not_queued got out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_mul();
    int          lat;
    logic [15:0] rc;
    logic        rofl, rerr;
    // Leave a nonzero result in the output registers first.
    run_op(4'h1, 16'hFFFF, 16'h0002, lat, rc, rofl, rerr);
    alu_op   = 4'h3;
    a        = 16'h0100;
    b        = 16'h0100;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || c !== 16'h0 || ofl !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL midmul_reset got out_valid=%b c=%h ofl=%b err=%b exp 0 0000 0 0",
               out_valid, c, ofl, err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midmul_release got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
    end
    run_op(4'h1, 16'h1234, 16'h1111, lat, rc, rofl, rerr);
    n_checks++;
    if (rc !== 16'h2345 || rofl !== 1'b0 || rerr !== 1'b0 || lat != 2) begin
      n_fail++;
      $display("FAIL midmul_next_add got c=%h ofl=%b err=%b lat=%0d exp 2345 0 0 2",
               rc, rofl, rerr, lat);
    end
  endtask

  task automatic test_back_to_back();
    int          lat;
    logic [15:0] rc;
    logic        rofl, rerr;
    run_op(4'h3, 16'h0012, 16'h0034, lat, rc, rofl, rerr);
    n_checks++;
    if (rc !== 16'h03A8 || rofl !== 1'b0 || rerr !== 1'b0 || lat != 17) begin
      n_fail++;
      $display("FAIL b2b_mul got c=%h ofl=%b err=%b lat=%0d exp 03A8 0 0 17", rc, rofl, rerr, lat);
    end
    run_op(4'h2, 16'h0000, 16'h0001, lat, rc, rofl, rerr);
    n_checks++;
    if (rc !== 16'hFFFF || rofl !== 1'b1 || rerr !== 1'b0 || lat != 2) begin
      n_fail++;
      $display("FAIL b2b_sub got c=%h ofl=%b err=%b lat=%0d exp FFFF 1 0 2", rc, rofl, rerr, lat);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_muldiv();
    test_shift();
    test_stall();
    test_reset_mid_mul();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
